// File: rtl/burst_issuer_pkg.sv
// Shared types and default widths for the burst issuer and its descriptor FIFO.
package burst_pkg;

  localparam int unsigned W_DEF     = 16;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic [W_DEF-1:0]     base;
    logic [LEN_W_DEF-1:0] len;
  } desc_t;

endpackage

// File: rtl/burst_issuer_if.sv
// Descriptor request port plus the load/feedback link to the downstream address counter.
interface burst_issuer_if #(
  parameter int unsigned W     = burst_pkg::W_DEF,
  parameter int unsigned LEN_W = burst_pkg::LEN_W_DEF
);
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_base;
  logic [LEN_W-1:0] req_len;
  logic             en;
  logic [W-1:0]     inp;
  logic [W-1:0]     cnt_fb;

  modport slave (
    input  req_valid, req_base, req_len, cnt_fb,
    output req_ready, en, inp
  );

  modport master (
    output req_valid, req_base, req_len, cnt_fb,
    input  req_ready, en, inp
  );
endinterface

// File: rtl/burst_issuer_fifo.sv
// Synchronous descriptor FIFO; a push becomes visible at the head one cycle later.
module burst_fifo #(
  parameter type         T     = burst_pkg::desc_t,
  parameter int unsigned DEPTH = burst_pkg::DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/burst_issuer.sv
// Burst sequencer: pops descriptors, strobes the counter load, times each burst
// and flags any divergence between the counter's cnt and the local beat count.
module burst_issuer
  import burst_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  burst_issuer_if.slave  bus,
  output logic           busy,
  output logic           last,
  output logic           err
);
  typedef struct packed {
    logic [W-1:0]     base;
    logic [LEN_W-1:0] len;
  } desc_w_t;

  desc_w_t          din, head;
  logic             full, empty, push, pop, issue;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] b_q, b_d, len_q, len_d;
  logic             en_q, en_d;
  logic [W-1:0]     inp_q, inp_d;
  logic             err_q, err_d;

  assign bus.req_ready = !full && !rst;
  assign push          = bus.req_valid && bus.req_ready;
  assign din           = '{base: bus.req_base, len: bus.req_len};

  burst_fifo #(
    .T     (desc_w_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.en  = en_q;
  assign bus.inp = inp_q;
  assign busy    = (state_q != IDLE);
  assign last    = (state_q == RUN) && (b_q == len_q);
  assign err     = err_q;
  // A new descriptor is taken either from idle or on the final beat, so bursts chain with no gap.
  assign issue   = !empty && ((state_q == IDLE) || last);

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    len_d   = len_q;
    en_d    = 1'b0;
    inp_d   = inp_q;
    err_d   = err_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        b_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        b_d = b_q + LEN_W'(1);
        if (bus.cnt_fb != W'(b_q)) err_d = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      pop     = 1'b1;
      len_d   = head.len;
      inp_d   = head.base;
      en_d    = 1'b1;
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      inp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      len_q   <= len_d;
      en_q    <= en_d;
      inp_q   <= inp_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_burst_issuer.sv
// Directed bench for burst_issuer with a behavioural model of the downstream address counter.
module tb_burst_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, last, err;
  logic stuck = 1'b0;
  logic [15:0] m_cnt, m_addr;
  int checks = 0;
  int errors = 0;

  burst_issuer_if #(.W(16), .LEN_W(8)) bus ();

  burst_issuer #(.W(16), .LEN_W(8), .DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .last (last),
    .err  (err)
  );

  always #5 clk = ~clk;

  // Downstream counter: load on en, otherwise step.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt  <= '0;
      m_addr <= '0;
    end else if (bus.en) begin
      m_cnt  <= '0;
      m_addr <= bus.inp;
    end else begin
      m_cnt  <= m_cnt + 16'd1;
      m_addr <= m_addr + 16'd1;
    end
  end
  assign bus.cnt_fb = stuck ? 16'h0000 : m_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_base  = '0;
    bus.req_len   = '0;
    repeat (3) step();
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", bus.en); end
    checks++; if (bus.inp !== 16'h0000) begin errors++; $display("FAIL reset_inp: got %h exp 0000", bus.inp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b exp 0", last); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b exp 0", bus.req_ready); end
    rst = 1'b0;
    step();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_single();
    bus.req_valid = 1'b1; bus.req_base = 16'h0100; bus.req_len = 8'd3;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL single_en_t1: got %b exp 0", bus.en); end
    step();
    checks++; if (bus.en !== 1'b1) begin errors++; $display("FAIL single_en_t2: got %b exp 1", bus.en); end
    checks++; if (bus.inp !== 16'h0100) begin errors++; $display("FAIL single_inp: got %h exp 0100", bus.inp); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_load: got %b exp 1", busy); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL single_run_en[%0d]: got %b exp 0", k, bus.en); end
      checks++; if (last !== (k == 3)) begin errors++; $display("FAIL single_last[%0d]: got %b exp %b", k, last, (k == 3)); end
      checks++; if (bus.cnt_fb !== 16'(k)) begin errors++; $display("FAIL single_cnt[%0d]: got %h exp %h", k, bus.cnt_fb, 16'(k)); end
      checks++; if (m_addr !== 16'h0100 + 16'(k)) begin errors++; $display("FAIL single_addr[%0d]: got %h exp %h", k, m_addr, 16'h0100 + 16'(k)); end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    // Expected per cycle t+2..t+7, bit i = cycle t+2+i.
    logic [5:0] en_e   = 6'b000101;
    logic [5:0] last_e = 6'b010010;
    logic [5:0] busy_e = 6'b011111;
    bus.req_valid = 1'b1; bus.req_base = 16'h0200; bus.req_len = 8'd0;
    step();
    bus.req_base = 16'h0300; bus.req_len = 8'd1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", bus.req_ready); end
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.en !== en_e[i]) begin errors++; $display("FAIL b2b_en[t+%0d]: got %b exp %b", i + 2, bus.en, en_e[i]); end
      checks++; if (last !== last_e[i]) begin errors++; $display("FAIL b2b_last[t+%0d]: got %b exp %b", i + 2, last, last_e[i]); end
      checks++; if (busy !== busy_e[i]) begin errors++; $display("FAIL b2b_busy[t+%0d]: got %b exp %b", i + 2, busy, busy_e[i]); end
      if (i == 0) begin
        checks++; if (bus.inp !== 16'h0200) begin errors++; $display("FAIL b2b_inp0: got %h exp 0200", bus.inp); end
      end
      if (i == 2) begin
        checks++; if (bus.inp !== 16'h0300) begin errors++; $display("FAIL b2b_inp1: got %h exp 0300", bus.inp); end
      end
      step();
    end
  endtask

  task automatic test_full();
    int waited;
    int pulses;
    logic [15:0] last_inp;
    bus.req_valid = 1'b1; bus.req_base = 16'h1000; bus.req_len = 8'hFF;
    step();
    for (int i = 1; i <= 4; i++) begin
      bus.req_base = 16'h2000 + 16'(i) * 16'h0100; bus.req_len = 8'd0;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %b exp 1", i, bus.req_ready); end
      step();
    end
    bus.req_base = 16'h2500; bus.req_len = 8'd0;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_sixth: got %b exp 0", bus.req_ready); end
    waited = 0;
    while (!bus.req_ready && waited < 400) begin
      step();
      waited++;
    end
    checks++; if (waited !== 254) begin errors++; $display("FAIL full_wait_cycles: got %0d exp 254", waited); end
    pulses = 0;
    last_inp = '0;
    for (int c = 0; c < 40 && (busy || c == 0); c++) begin
      if (c == 1) bus.req_valid = 1'b0;
      if (bus.en) begin
        pulses++;
        last_inp = bus.inp;
      end
      step();
    end
    bus.req_valid = 1'b0;
    checks++; if (pulses !== 5) begin errors++; $display("FAIL full_drain_pulses: got %0d exp 5", pulses); end
    checks++; if (last_inp !== 16'h2500) begin errors++; $display("FAIL full_last_inp: got %h exp 2500", last_inp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain_idle: got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b exp 0", err); end
  endtask

  task automatic test_wrap();
    logic [15:0] addr_e [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bus.req_valid = 1'b1; bus.req_base = 16'hFFFE; bus.req_len = 8'd3;
    step();
    bus.req_valid = 1'b0;
    step();
    checks++; if (bus.inp !== 16'hFFFE) begin errors++; $display("FAIL wrap_inp: got %h exp FFFE", bus.inp); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (m_addr !== addr_e[k]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h exp %h", k, m_addr, addr_e[k]); end
      checks++; if (last !== (k == 3)) begin errors++; $display("FAIL wrap_last[%0d]: got %b exp %b", k, last, (k == 3)); end
    end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b exp 0", err); end
  endtask

  task automatic test_mismatch();
    stuck = 1'b1;
    bus.req_valid = 1'b1; bus.req_base = 16'h0400; bus.req_len = 8'd2;
    step();
    bus.req_valid = 1'b0;
    repeat (2) step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mism_err_run0: got %b exp 0", err); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mism_err_run1: got %b exp 0", err); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mism_err_run2: got %b exp 1", err); end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL mism_last_run2: got %b exp 1", last); end
    stuck = 1'b0;
    step();
    bus.req_valid = 1'b1; bus.req_base = 16'h0480; bus.req_len = 8'd1;
    step();
    bus.req_valid = 1'b0;
    repeat (4) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mism_busy_after: got %b exp 0", busy); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mism_err_sticky: got %b exp 1", err); end
  endtask

  task automatic test_rst_mid();
    bus.req_valid = 1'b1; bus.req_base = 16'h0500; bus.req_len = 8'd5;
    step();
    bus.req_base = 16'h0600; bus.req_len = 8'd1;
    step();
    bus.req_base = 16'h0700; bus.req_len = 8'd1;
    checks++; if (bus.en !== 1'b1) begin errors++; $display("FAIL rstm_en_load: got %b exp 1", bus.en); end
    step();
    bus.req_valid = 1'b0;
    repeat (2) step();
    checks++; if (bus.cnt_fb !== 16'd2) begin errors++; $display("FAIL rstm_cnt_run2: got %h exp 0002", bus.cnt_fb); end
    rst = 1'b1;
    step();
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL rstm_en: got %b exp 0", bus.en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstm_busy: got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstm_err: got %b exp 0", err); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rstm_ready_in_rst: got %b exp 0", bus.req_ready); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL rstm_no_en[%0d]: got %b exp 0", i, bus.en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstm_no_busy[%0d]: got %b exp 0", i, busy); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready[%0d]: got %b exp 1", i, bus.req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_mismatch();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/burst_issuer.md
# burst_issuer

Upstream sequencer for the address/beat counter (`base`/`addr`/`cnt` with load-on-`en`). It accepts burst descriptors (start address, beat count) over a valid/ready port and buffers them in a small FIFO. For each descriptor it pulses `en` with `inp` = start address, then holds `en` low for exactly the burst length while the counter steps. It checks the counter's `cnt` feedback against its own beat count and flags any divergence.

## Interface
- `W`, 16: address/counter width; must match the downstream counter.
- `LEN_W`, 8: descriptor length field width.
- `DEPTH`, 4: descriptor FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  descriptor offered.
- `req_ready`  out  1  FIFO can accept; `!full`, forced 0 while `rst`.
- `req_base`  in  W  burst start address.
- `req_len`  in  LEN_W  beats minus one (encodes 1..2^LEN_W beats).
- `en`  out  1  registered; load strobe to counter.
- `inp`  out  W  registered; start address to counter, valid when `en`=1.
- `cnt_fb`  in  W  counter's `cnt` output.
- `busy`  out  1  state ≠ IDLE.
- `last`  out  1  final beat cycle of current burst.
- `err`  out  1  sticky feedback-mismatch flag.

## Operation
- FSM states IDLE, LOAD, RUN.
- IDLE: if FIFO non-empty, pop head, latch `len`, set `en`<=1 and `inp`<=head.base, go LOAD; else hold `en`=0.
- LOAD: `en`=1 for exactly one cycle. The counter loads at the closing edge. Next state RUN with `en`<=0, beat counter b<=0.
- RUN: `en`=0. b increments each cycle.
  - `last` = (state==RUN && b==len).
  - On the `last` cycle: if FIFO non-empty, pop and go LOAD (no idle gap, `en`=1 next cycle); else go IDLE.
- Burst of len+1 beats. The counter's `addr` in RUN cycle k equals base+k mod 2^W; the issuer does not track `addr`.
- Check: in every RUN cycle, if `cnt_fb` ≠ zero-extended b, `err`<=1 at that cycle's closing edge. `err` clears only on `rst`.
- b width: LEN_W+... no extension needed; b counts 0..len within LEN_W bits and never wraps.
- FIFO: push on `req_valid && req_ready`. No bypass: a descriptor pushed into an empty FIFO is visible to the FSM the next cycle. Simultaneous push and pop when not full are both performed. Pop never occurs when empty.
- `inp` holds its last value outside LOAD.

## Timing
- Reset values: `en`=0, `inp`=0, `busy`=0, `last`=0, `err`=0, FIFO empty, state IDLE, b=0. `req_ready` is 1 the first cycle after `rst` deasserts.
- Latency: handshake in cycle t with FSM idle → `en`=1 in cycle t+2, RUN cycles t+3..t+3+len, `last` in t+3+len.
- Back-to-back: the next `en` occurs the cycle after `last`, so the per-burst period is len+2 cycles.
- `rst` mid-burst: the FSM returns to IDLE at that edge, queued descriptors are discarded, and `en`=0 from the next cycle.
- `req_valid` need not be held; no combinational path from `req_valid` to `req_ready`.

## Structure
- Package `burst_pkg`: FSM state enum (IDLE/LOAD/RUN), default width constants, descriptor struct {base, len}.
- Sub-module `burst_fifo`: synchronous FIFO of descriptors with `full`/`empty` flags and one-cycle-visible push. The FSM, beat counter and check logic live in the top.

## Test plan
- Single request base=0x0100, len=3, accepted in cycle 10 → `en`=1 with `inp`=0x0100 in cycle 12. RUN cycles 13–16 with model `cnt_fb` 0..3. `last` in cycle 16, `busy` low in cycle 17, `err`=0.
- Two queued requests (0x0200 len=0, 0x0300 len=1) → `en` pulses in cycles t+2 and t+4. `last` in t+3 and t+6; no IDLE cycle between bursts.
- First request len=0xFF, then five more offered back-to-back → four are accepted and `req_ready`=0 for the sixth. It is accepted the cycle after the `last` of the first burst pops an entry.
- Wrap: base=0xFFFE, len=3 → `inp`=0xFFFE. The counter model shows `addr` FFFE, FFFF, 0000, 0001 across the four RUN cycles; `last` on the fourth and `err`=0.
- Mismatch: `cnt_fb` stuck at 0 during a len=2 burst → `err`=1 from the cycle after RUN cycle 1. It remains 1 through later bursts until `rst`.
- `rst` asserted in RUN cycle 2 of a len=5 burst with two queued descriptors → next cycle `en`=0, `busy`=0, FIFO empty. No further `en` until a new handshake.
